ls_sequencer: RTL and testbench
===============================

// Module: ls_sequencer
// PURPOSE
//  Multicycle sequencer for load/store memory accesses.
//  - Takes one request at a time from the main control unit.
//  - Drives memory read/write strobes and the MDR write enable.
//  - Drives the 2-bit size code of the registered store-merge unit
//    (01 byte, 10 half, 11 word).
//  - Sub-word stores (sb/sh) run as read-modify-write: read the word,
//    merge it, then write it back.
//  - Word stores skip the read. Loads read the word and capture it in MDR.
// PARAMETERS
//  MEM_LAT  2   memory read latency in cycles; legal range 1..7
//  ADDR_W   32  address width
// PORTS
//  clock       in   1       system clock, rising edge
//  reset_n     in   1       asynchronous, active-low reset
//  req_valid   in   1       request present
//  req_ready   out  1       sequencer can accept a request (IDLE only)
//  req_store   in   1       1 = store, 0 = load
//  req_size    in   2       01 byte, 10 half, 11 word, 00 illegal
//  req_addr    in   ADDR_W  byte address
//  mem_addr    out  ADDR_W  registered request address
//  mem_rd      out  1       memory read strobe
//  mem_wr      out  1       memory write strobe
//  mdr_wr      out  1       MDR capture enable (loads)
//  ls_ctrl     out  2       merge-unit size code; 00 = hold
//  busy        out  1       1 in any state except IDLE
//  done        out  1       one-cycle completion pulse
//  err         out  1       one-cycle error pulse, coincident with done
// BEHAVIOUR
//  Reset (reset_n=0, asynchronous):
//   - state <= IDLE; wait counter <= 0; mem_addr <= 0.
//   - mem_rd, mem_wr, mdr_wr, ls_ctrl, done, err, busy all 0 immediately.
//   - req_ready=1 after release.
//   - Reset mid-operation abandons the access; no partial write is issued.
//  Handshake:
//   - Accept when req_valid & req_ready on a rising edge.
//   - req_store, req_size, req_addr are registered at accept; later input
//     changes are ignored.
//   - req_ready is 0 in DONE/ERR, so back-to-back requests are accepted the
//     cycle after done.
//  States (all outputs registered / decoded from state):
//   - IDLE: req_ready=1. On accept:
//     - size 00 -> ERR
//     - load or sub-word store -> RD
//     - word store -> MERGE
//   - RD: mem_rd=1 for exactly MEM_LAT cycles (3-bit counter, counts 0..MEM_LAT-1).
//     - Exit to CAP for a load, MERGE for a store.
//   - CAP: mdr_wr=1 for one cycle -> DONE.
//   - MERGE: ls_ctrl=registered size for one cycle. The merge unit registers
//     its output on this edge. -> WRITE.
//   - WRITE: mem_wr=1 for one cycle -> DONE.
//   - DONE: done=1 for one cycle -> IDLE.
//   - ERR: done=1, err=1 for one cycle -> IDLE. No mem_rd/mem_wr issued.
//  Output rules:
//   - ls_ctrl=00 in every state except MERGE.
//   - mem_rd and mem_wr are never high together.
//   - busy=1 from the cycle after accept through DONE/ERR.
//   - mem_addr is valid from the cycle after accept until the next accept.
//  Latency, cycles from the accept edge to the done pulse:
//   - load: MEM_LAT+2
//   - sub-word store: MEM_LAT+3
//   - word store: 3
//   - error: 1
//  Counter boundary: with MEM_LAT=1, RD lasts exactly one cycle. The counter
//   clears on RD exit so the next access starts from 0.
// CONFIGURATION
//  ALIGN_CHECK_EN defined:
//   - At accept, half with addr[0]!=0 or word with addr[1:0]!=0 -> ERR.
//   - Byte accesses are never misaligned.
//  ALIGN_CHECK_EN undefined:
//   - No alignment check; only size 00 -> ERR.
//   - Misaligned accesses run normally using the address as given.
// TESTING (MEM_LAT=2, accept at cycle 0)
//  1. lw 0x40 -> mem_rd=1 cyc 1-2, mdr_wr=1 cyc 3, done cyc 4, mem_wr never,
//     mem_addr=0x40.
//  2. sb 0x41 -> mem_rd cyc 1-2, ls_ctrl=01 cyc 3, mem_wr cyc 4, done cyc 5,
//     ls_ctrl=00 elsewhere.
//  3. sw 0x80 -> ls_ctrl=11 cyc 1, mem_wr cyc 2, done cyc 3, mem_rd never.
//     With req_valid held high, the next request is accepted at cyc 4.
//  4. req_size=00 -> done=1, err=1 at cyc 1; mem_rd/mem_wr stay 0;
//     req_ready=1 at cyc 2.
//  5. sh 0x44, reset_n=0 mid-RD (cyc 1) -> all outputs 0 asynchronously,
//     no mem_wr ever; after release req_ready=1 and a new lw completes normally.
//  6. sh 0x43:
//     - ALIGN_CHECK_EN defined: err at cyc 1, no memory access.
//     - Undefined: normal 5-cycle RMW with ls_ctrl=10.

Source files
------------

// File: rtl/ls_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ls_sequencer
//  Purpose  : Multicycle sequencer for load/store memory accesses. Accepts
//             one request at a time, drives the memory read/write strobes,
//             the MDR capture enable and the size code of the registered
//             store-merge unit. Sub-word stores run read-modify-write; word
//             stores skip the read; loads read and capture into MDR.
//  Params   : MEM_LAT - memory read latency in cycles (1..7)
//             ADDR_W  - address width (>= 2)
//  Ports    : clock, reset_n (async, active-low)
//             req_valid/req_ready handshake, req_store, req_size, req_addr
//             mem_addr, mem_rd, mem_wr, mdr_wr, ls_ctrl, busy, done, err
//  Config   : ALIGN_CHECK_EN - when defined, misaligned half/word requests
//             are rejected with an error pulse instead of being executed.
//  Revision : 1.0 - initial release
// ============================================================================
module ls_sequencer #(
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mdr_wr,
  output logic [1:0]        ls_ctrl,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] C_RD_LAST = 3'(MEM_LAT - 1);
  localparam logic [1:0] C_SZ_WORD = 2'b11;
  localparam logic [1:0] C_SZ_HALF = 2'b10;
  localparam logic [1:0] C_SZ_BAD  = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_CAP   = 3'd2,
    S_MERGE = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_cnt;
  logic       r_store;
  logic [1:0] r_size;
  logic       w_accept;
  logic       w_bad;
  logic       w_rd_last;

  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_rd_last = (r_cnt == C_RD_LAST);

`ifdef ALIGN_CHECK_EN
  // Bytes can never be misaligned; halves need bit 0 clear, words bits 1:0.
  assign w_bad = (req_size == C_SZ_BAD)
              || ((req_size == C_SZ_HALF) && req_addr[0])
              || ((req_size == C_SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign w_bad = (req_size == C_SZ_BAD);
`endif

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Request capture: inputs are only looked at on the accept edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr <= '0;
      r_store  <= 1'b0;
      r_size   <= 2'b00;
    end else if (w_accept) begin
      mem_addr <= req_addr;
      r_store  <= req_store;
      r_size   <= req_size;
    end
  end

  // Read wait counter; clears on the RD exit so every access starts at 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= 3'd0;
    end else if (r_state == S_RD) begin
      r_cnt <= w_rd_last ? 3'd0 : (r_cnt + 3'd1);
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mdr_wr       = 1'b0;
    ls_ctrl      = 2'b00;
    busy         = 1'b1;
    done         = 1'b0;
    err          = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (w_accept) begin
          if (w_bad) begin
            w_state_next = S_ERR;
          end else if (req_store && (req_size == C_SZ_WORD)) begin
            w_state_next = S_MERGE;
          end else begin
            w_state_next = S_RD;
          end
        end
      end
      S_RD: begin
        mem_rd = 1'b1;
        if (w_rd_last) begin
          w_state_next = r_store ? S_MERGE : S_CAP;
        end
      end
      S_CAP: begin
        mdr_wr       = 1'b1;
        w_state_next = S_DONE;
      end
      S_MERGE: begin
        // The merge unit registers the merged word on the edge ending this cycle.
        ls_ctrl      = r_size;
        w_state_next = S_WRITE;
      end
      S_WRITE: begin
        mem_wr       = 1'b1;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      S_ERR: begin
        done         = 1'b1;
        err          = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ls_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ls_sequencer
//  Purpose  : Self-checking bench for ls_sequencer (MEM_LAT=2). Each request
//             pushes its expected per-cycle output trace into a scoreboard
//             queue; entries are popped and compared cycle by cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ls_sequencer;

  localparam int MEM_LAT = 2;
  localparam int ADDR_W  = 32;

  logic              clock;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic              mdr_wr;
  logic [1:0]        ls_ctrl;
  logic              busy;
  logic              done;
  logic              err;

  ls_sequencer #(.MEM_LAT(MEM_LAT), .ADDR_W(ADDR_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_store (req_store),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mdr_wr    (mdr_wr),
    .ls_ctrl   (ls_ctrl),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [8:0]        v;  // {ready,busy,rd,wr,mdr,ls[1:0],done,err}
    logic [ADDR_W-1:0] a;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  function automatic logic [8:0] obs_vec();
    return {req_ready, busy, mem_rd, mem_wr, mdr_wr, ls_ctrl, done, err};
  endfunction

  function automatic logic [8:0] ev(bit rdy, bit bsy, bit rd, bit wr, bit mdr,
                                    logic [1:0] ls, bit dn, bit er);
    return {rdy, bsy, rd, wr, mdr, ls, dn, er};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Drive one request in the current (IDLE) cycle, build its expected trace
  // from the documented latencies, then compare every following cycle up to
  // and including the first IDLE cycle after done.
  task automatic run_req(input string tag, input bit st, input logic [1:0] sz,
                         input logic [ADDR_W-1:0] ad, input bit hold);
    bit   is_err;
    exp_t e;
    int   k;
    req_valid = 1'b1;
    req_store = st;
    req_size  = sz;
    req_addr  = ad;
    check({tag, " ready@0"}, 64'(req_ready), 64'd1);

    is_err = (sz == 2'b00);
`ifdef ALIGN_CHECK_EN
    if ((sz == 2'b10 && ad[0]) || (sz == 2'b11 && ad[1:0] != 2'b00)) is_err = 1'b1;
`endif
    e.a = ad;
    if (is_err) begin
      e.v = ev(0, 1, 0, 0, 0, 2'b00, 1, 1); q.push_back(e);
    end else if (!st) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        e.v = ev(0, 1, 1, 0, 0, 2'b00, 0, 0); q.push_back(e);
      end
      e.v = ev(0, 1, 0, 0, 1, 2'b00, 0, 0); q.push_back(e);
      e.v = ev(0, 1, 0, 0, 0, 2'b00, 1, 0); q.push_back(e);
    end else begin
      if (sz != 2'b11) begin
        for (int i = 0; i < MEM_LAT; i++) begin
          e.v = ev(0, 1, 1, 0, 0, 2'b00, 0, 0); q.push_back(e);
        end
      end
      e.v = ev(0, 1, 0, 0, 0, sz, 0, 0);    q.push_back(e);
      e.v = ev(0, 1, 0, 1, 0, 2'b00, 0, 0); q.push_back(e);
      e.v = ev(0, 1, 0, 0, 0, 2'b00, 1, 0); q.push_back(e);
    end
    e.v = ev(1, 0, 0, 0, 0, 2'b00, 0, 0); q.push_back(e);

    k = 0;
    while (q.size() > 0) begin
      @(posedge clock); #1;
      k++;
      if (!hold) begin
        // Scramble the request inputs; the sequencer must ignore them.
        req_valid = 1'b0;
        req_store = ~st;
        req_size  = ~sz;
        req_addr  = 32'hDEAD_BEEF;
      end
      e = q.pop_front();
      check($sformatf("%s outs@%0d", tag, k), 64'(obs_vec()), 64'(e.v));
      check($sformatf("%s addr@%0d", tag, k), 64'(mem_addr), 64'(e.a));
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_store = 1'b0;
    req_size  = 2'b00;
    req_addr  = '0;

    // Reset state (req_ready excluded while reset is asserted)
    #3;
    check("reset outs", 64'(obs_vec() & 9'h0FF), 64'd0);
    check("reset addr", 64'(mem_addr), 64'd0);
    @(posedge clock); #2;
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("ready after reset", 64'(req_ready), 64'd1);

    run_req("lw40",  1'b0, 2'b11, 32'h40, 1'b0);
    run_req("sb41",  1'b1, 2'b01, 32'h41, 1'b0);
    // Word store with req_valid held high; the next request is taken at cyc 4
    run_req("sw80",  1'b1, 2'b11, 32'h80, 1'b1);
    run_req("lw84",  1'b0, 2'b11, 32'h84, 1'b0);
    run_req("size0", 1'b0, 2'b00, 32'h90, 1'b0);
    run_req("sh43",  1'b1, 2'b10, 32'h43, 1'b0);
    run_req("lh46",  1'b0, 2'b10, 32'h46, 1'b0);
    run_req("lb47",  1'b0, 2'b01, 32'h47, 1'b0);

    // Reset in the middle of the read phase of a half store
    req_valid = 1'b1;
    req_store = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h44;
    @(posedge clock); #1;
    req_valid = 1'b0;
    check("sh44 rd@1", 64'(obs_vec()), 64'(ev(0, 1, 1, 0, 0, 2'b00, 0, 0)));
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset outs", 64'(obs_vec() & 9'h0FF), 64'd0);
    check("async reset addr", 64'(mem_addr), 64'd0);
    @(posedge clock); #1;
    check("held reset outs", 64'(obs_vec() & 9'h0FF), 64'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      check($sformatf("post-reset idle@%0d", i), 64'(obs_vec()),
            64'(ev(1, 0, 0, 0, 0, 2'b00, 0, 0)));
    end
    run_req("lw40b", 1'b0, 2'b11, 32'h40, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
